// File: rtl/quire_pkg.sv
// Shared sizing, FSM states and segment addressing for the quire accumulator.
package quire_pkg;

  localparam int SEG_W     = 64;
  localparam int N_SEG     = 8;
  localparam int FLUSH_CYC = 8;

  localparam int IDX_W = $clog2(N_SEG);
  localparam int CNT_W = $clog2((FLUSH_CYC > N_SEG) ? FLUSH_CYC : N_SEG);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Even slices land on even segments, odd slices on the segment just above.
  function automatic logic [IDX_W-1:0] seg_sel(input logic [1:0] adr, input logic odd);
    return {adr, odd};
  endfunction

endpackage

// File: rtl/quire_segment.sv
// One carry-save quire segment: a value register plus its pending carry.
module quire_segment
  import quire_pkg::*;
#(
  parameter int W = SEG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic [W-1:0] i_op,
  input  logic         i_cin,
  output logic [W-1:0] o_q,
  output logic         o_cout
);

  logic [W-1:0] r_q;
  logic         r_c;
  logic [W:0]   w_sum;

  assign w_sum  = {1'b0, r_q} + {1'b0, i_op} + {{W{1'b0}}, i_cin};
  assign o_q    = r_q;
  assign o_cout = r_c;

  // Add operand and neighbour carry; the carry-out waits one cycle in r_c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      r_c <= 1'b0;
    end else if (i_clear) begin
      r_q <= '0;
      r_c <= 1'b0;
    end else begin
      r_q <= w_sum[W-1:0];
      r_c <= w_sum[W];
    end
  end

endmodule

// File: rtl/quire_accumulator.sv
// Exact 512-bit carry-save quire: accumulates product slices, resolves
// carries on finish, then streams the quire out LSB segment first.
module quire_accumulator
  import quire_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             finish,
  input  logic             isInf,
  input  logic [SEG_W-1:0] frac_even,
  input  logic [SEG_W-1:0] frac_odd,
  input  logic [1:0]       adr_even,
  input  logic [1:0]       adr_odd,
  input  logic             sign_even,
  input  logic             sign_odd,
  output logic             in_ready,
  output logic             overrun,
  output logic             out_valid,
  output logic [SEG_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_nar
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_nar;
  logic               w_accept;
  logic               w_clear;
  logic               w_last_drain;

  logic [IDX_W-1:0]   w_seg_even;
  logic [IDX_W-1:0]   w_seg_odd;
  logic [IDX_W-1:0]   w_upper;
  logic               w_upper_sign;
  logic [SEG_W-1:0]   w_op [N_SEG];
  logic [SEG_W-1:0]   w_q  [N_SEG];
  logic [N_SEG-1:0]   w_cin;
  logic [N_SEG-1:0]   w_cout;
  logic               w_unused_cout;

  logic               r_overrun;
  logic               r_out_valid;
  logic [SEG_W-1:0]   r_out_data;
  logic [IDX_W-1:0]   r_out_idx;
  logic               r_out_last;
  logic               r_out_nar;

  assign in_ready     = (r_state == ACC);
  assign w_accept     = valid & in_ready;
  assign w_last_drain = (r_state == DRAIN) && (r_cnt == CNT_W'(N_SEG - 1));
  assign w_clear      = w_last_drain;

  // Steer the two slices onto their segments and sign-extend above the upper one.
  always_comb begin
    w_seg_even   = seg_sel(adr_even, 1'b0);
    w_seg_odd    = seg_sel(adr_odd, 1'b1);
    w_upper      = (w_seg_odd > w_seg_even) ? w_seg_odd : w_seg_even;
    w_upper_sign = (w_seg_odd > w_seg_even) ? sign_odd : sign_even;
    for (int k = 0; k < N_SEG; k++) begin
      w_op[k] = '0;
      if (w_accept) begin
        if (IDX_W'(k) == w_seg_even) begin
          w_op[k] = frac_even;
        end else if (IDX_W'(k) == w_seg_odd) begin
          w_op[k] = frac_odd;
        end else if ((IDX_W'(k) > w_upper) && w_upper_sign) begin
          w_op[k] = '1;
        end
      end
    end
  end

  // Segment chain; the carry out of the top segment wraps away (mod 2^512).
  for (genvar k = 0; k < N_SEG; k++) begin : g_seg
    if (k == 0) begin : g_cin0
      assign w_cin[k] = 1'b0;
    end else begin : g_cink
      assign w_cin[k] = w_cout[k-1];
    end
    quire_segment #(.W(SEG_W)) u_seg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_clear),
      .i_op    (w_op[k]),
      .i_cin   (w_cin[k]),
      .o_q     (w_q[k]),
      .o_cout  (w_cout[k])
    );
  end
  assign w_unused_cout = w_cout[N_SEG-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_next;
  end

  // Next state: ACC until finish, fixed-length FLUSH, then one DRAIN beat per segment.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACC:     if (finish) w_next = FLUSH;
      FLUSH:   if (r_cnt == CNT_W'(FLUSH_CYC - 1)) w_next = DRAIN;
      DRAIN:   if (w_last_drain) w_next = ACC;
      default: w_next = ACC;
    endcase
  end

  // Phase counter: restarts on every state change, idle in ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == ACC) || (r_state != w_next)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Sticky NaR flag for the current dot product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nar <= 1'b0;
    end else if (w_clear) begin
      r_nar <= 1'b0;
    end else if (w_accept && isInf) begin
      r_nar <= 1'b1;
    end
  end

  // Output beats and the overrun pulse for inputs offered while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_nar   <= 1'b0;
    end else begin
      r_overrun   <= (valid | finish) & ~in_ready;
      r_out_valid <= (r_state == DRAIN);
      r_out_last  <= w_last_drain;
      if (r_state == DRAIN) begin
        r_out_data <= w_q[r_cnt[IDX_W-1:0]];
        r_out_idx  <= r_cnt[IDX_W-1:0];
        r_out_nar  <= r_nar;
      end
    end
  end

  assign overrun   = r_overrun;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign out_nar   = r_out_nar;

endmodule

// File: doc/quire_accumulator.md
# quire_accumulator

Exact 512-bit quire accumulator for the posit32 multiply-accumulate datapath. It consumes the aligned even/odd 64-bit product slices from the multiplier/aligner stage, one product per accepted beat. Accumulation is carry-save across eight 64-bit segments. On `finish` it resolves the pending carries and streams the signed quire out LSB-segment first, then clears itself for the next dot product.

## Interface
- `SEG_W`, 64, segment width in bits
- `N_SEG`, 8, number of segments (quire = 512 bits)
- `FLUSH_CYC`, 8, carry-resolve cycles (must be ≥ `N_SEG`-1)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid`  in  1  product slice beat present
- `finish`  in  1  end of dot product (sampled when `in_ready`)
- `isInf`  in  1  beat carries NaR
- `frac_even`, `frac_odd`  in  64 each  two's-complement slices
- `adr_even`, `adr_odd`  in  2 each  slice addresses
- `sign_even`, `sign_odd`  in  1 each  sign-extension bit of each slice
- `in_ready`  out  1  high in ACC state only
- `overrun`  out  1  one-cycle pulse: `valid` or `finish` arrived while `in_ready`=0
- `out_valid`  out  1  quire segment beat
- `out_data`  out  64  segment value
- `out_idx`  out  3  segment index 0..7
- `out_last`  out  1  high with `out_idx`=7
- `out_nar`  out  1  result is NaR, held constant over all 8 beats

## Operation
- Segment map:
  - The even slice goes to segment 2·`adr_even`.
  - The odd slice goes to segment 2·`adr_odd`+1.
  - The upper slice is the one with the higher segment index. Every segment above it receives all-ones when that slice's sign bit is 1, else zero.
  - Any segment that is neither addressed nor above the upper slice receives zero.
- Per accepted beat, for each segment k: {c[k], Q[k]} ← Q[k] + op[k] + c[k-1].
  - c[-1]=0.
  - The carry out of segment 7 is discarded, giving modulo 2^512 two's-complement arithmetic.
- Idle cycles in ACC still ripple carries with op=0.
- NaR flag: a sticky `nar` register is set by any accepted beat with `valid`&`isInf`.
- States:
  - ACC → FLUSH: when `finish`&`in_ready`. A same-cycle `valid` beat is accumulated first.
  - FLUSH: `FLUSH_CYC` cycles, op=0, all carries drain to zero. Then go to DRAIN.
  - DRAIN: 8 cycles. Counter cnt runs 0..7, and each edge loads `out_data`←Q[cnt], `out_idx`←cnt, `out_valid`←1, `out_last`←(cnt==7), `out_nar`←`nar`.
  - DRAIN → ACC: on the last DRAIN edge, Q, c and `nar` are cleared.
- `finish` with `valid`=0 is legal: it closes the dot product with no further beat.
- `overrun` fires for inputs presented in FLUSH/DRAIN. Those inputs are dropped and the quire is unchanged.
- Reset (any time, including mid-FLUSH/DRAIN) takes effect immediately:
  - Q, c and `nar` are cleared and the state returns to ACC.
  - Every output goes to 0 except `in_ready`, which goes to 1.

## Timing
- A beat accepted in cycle T is in Q/c after the edge ending T.
- `finish` accepted in cycle T:
  - FLUSH occupies T+1..T+8.
  - DRAIN occupies T+9..T+16.
  - `out_valid` is high T+10..T+17, with `out_idx` 0..7 and `out_last` at T+17.
  - `in_ready`=1 again from T+17. A beat accepted in T+17 starts the next quire, while beat 7 of the previous quire is still on the output.
- `in_ready` is combinational from the state. All other outputs are registered.
- There is no output backpressure. The consumer must accept 8 consecutive beats.

## Structure
- `quire_pkg`: `SEG_W`, `N_SEG`, `FLUSH_CYC`, state enum {ACC, FLUSH, DRAIN}, and a segment-select function mapping (adr, even/odd) → segment index.
- Sub-module `quire_segment`: one 64-bit register plus its carry register. Inputs are op, carry-in and clear; outputs are value and carry-out. Instantiated `N_SEG` times.
- The top level holds the operand steering/sign-extension, the FSM, the counters, `nar` and the output registers.

## Test plan
- Single unit: `frac_even`=1, `adr_even`=0, `frac_odd`=0, `adr_odd`=0, signs 0, then `finish` → seg0=1, segs1–7=0, `out_last` at idx 7, `out_nar`=0.
- Carry ripple: two beats `frac_even`=FFFF_FFFF_FFFF_FFFF, `adr_even`=0, signs 0 → seg0=FFFF_FFFF_FFFF_FFFE, seg1=1, others 0.
- Cancel/sign extension:
  - Beat 1: +1 in seg0.
  - Beat 2: `frac_even`=all-ones, `sign_even`=1, `adr_even`=0, `frac_odd`=all-ones, `sign_odd`=1, `adr_odd`=0.
  - Required: all 8 segments = 0.
- NaR: one beat with `isInf`=1 → `out_nar`=1 on all 8 beats. The next dot product without `isInf` → `out_nar`=0.
- Overrun: `valid` at T+3 after `finish` at T → `overrun` pulse, result unchanged. A beat at T+17 appears only in the next quire.
- Reset mid-DRAIN: assert `rst_n`=0 at T+12 → `out_valid`=0 immediately, `in_ready`=1 after release, next quire starts from 0.
